window_stats: RTL
=================

Name: window_stats

Overview:
- Downstream consumer of the registered 32-bit data stage; takes its data output as a sample stream.
- Collects a fixed window of WINDOW valid samples and computes their sum, minimum and maximum.
- Presents the result on a valid/ready result port; samples arriving while a result is pending are counted as drops.
- Feeds the bench monitor/scoreboard and any later stats consumer.

Parameters:
- WIDTH, 32, sample width in bits (unsigned).
- WINDOW, 8, samples per window; legal range 2..256.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset_n  input  1  reset: synchronous, active-low; clock clk.
- start  input  1  one-cycle request to open a new window.
- in_valid  input  1  in_data carries a sample this cycle.
- in_data  input  WIDTH  sample value, unsigned.
- busy  output  1  high whenever state is not IDLE.
- res_valid  output  1  result registers hold a completed window.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  WIDTH+$clog2(WINDOW)  sum of the window samples.
- res_min  output  WIDTH  smallest sample in the window.
- res_max  output  WIDTH  largest sample in the window.
- drop_cnt  output  8  saturating count of samples rejected in REPORT.

Behaviour:
- State machine: IDLE, ACCUM, REPORT. All state and outputs are registered.
- Reset (reset_n==0 at a posedge):
  - state goes to IDLE.
  - busy, res_valid, res_sum, res_min, res_max and drop_cnt all go to 0.
  - Internal accumulators are cleared.
- IDLE:
  - in_valid is ignored and not counted as a drop.
  - start==1 moves to ACCUM and initialises: cnt=0, acc_sum=0, acc_min=all-ones, acc_max=0.
- ACCUM:
  - Each cycle with in_valid==1: acc_sum += in_data (zero-extended), acc_min = min(acc_min, in_data), acc_max = max(acc_max, in_data), cnt++. All compares are unsigned.
  - Cycles with in_valid==0 change nothing; gaps are allowed.
  - start is ignored.
  - When the WINDOW-th sample is accepted, the next cycle enters REPORT. res_sum/min/max then include that sample and res_valid==1. Latency is 1 cycle from the last accepted sample to res_valid.
- REPORT:
  - res_* are held stable while res_valid==1.
  - When res_valid && res_ready at a posedge, res_valid drops and state returns to IDLE.
  - res_ready may already be high on the first REPORT cycle; the handshake then completes at the next edge.
  - start during REPORT is ignored.
  - in_valid==1 during REPORT increments drop_cnt, saturating at 255.
  - drop_cnt is cleared only by reset.
- Width rule: the sum width of WIDTH+$clog2(WINDOW) cannot overflow; no wrap-around handling is needed.
- res_min/res_max keep their last reported values after the handshake; they are only rewritten on entry to REPORT.
- Reset mid-window: the partial window is discarded, nothing is reported, drop_cnt returns to 0.
- Simultaneous events:
  - start and in_valid in the same IDLE cycle: the sample is not counted; counting begins the cycle after start.
  - Handshake and in_valid in the same REPORT cycle: the sample counts as a drop.

Decomposition:
- Package window_stats_pkg holds:
  - the state_t enum (IDLE, ACCUM, REPORT);
  - DROP_W=8 and DROP_MAX=255;
  - a sum_width(width, window) function.
- One sub-module, window_stats_accum: the datapath holding acc_sum/acc_min/acc_max/cnt.
  - Inputs: clr, add, data.
  - Output: last (asserted when the WINDOW-th sample is being added).
- The FSM, result registers and drop counter stay in window_stats.

Test Plan:
1. WINDOW=4, start, samples 5,1,9,3 on consecutive cycles, res_ready=1 -> res_valid one cycle after the 3; sum=18, min=1, max=9; back to IDLE, busy=0.
2. WINDOW=4, four samples of 0xFFFFFFFF with idle gaps between them -> sum=0x3FFFFFFFC, min=max=0xFFFFFFFF; gaps do not change cnt.
3. Backpressure: after a window completes, hold res_ready=0 for 10 cycles with in_valid=1 -> res_* stable, drop_cnt=10; raise res_ready -> IDLE; samples then in IDLE do not change drop_cnt.
4. Drop saturation: 300 in_valid cycles in REPORT -> drop_cnt=255 and holds.
5. Reset mid-window: after 2 of 4 samples, reset_n=0 for one edge -> busy=0, res_valid=0, all outputs 0; a new start plus 4 samples of 7 -> sum=28, min=max=7.
6. start pulsed during ACCUM and during REPORT -> ignored, window count unaffected; start and in_valid together in IDLE -> that sample is excluded from the sum.

Source files
------------

// File: rtl/window_stats_pkg.sv
// window_stats_pkg: shared states, drop-counter limits and sum width helper.
package window_stats_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;
  function automatic int sum_width(input int width, input int window);
    return width + $clog2(window);
  endfunction
endpackage

// File: rtl/window_stats_accum.sv
// window_stats_accum: running sum/min/max/count of the open window; exposes next values.
module window_stats_accum import window_stats_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int WINDOW = 8,
  parameter int SW = sum_width(WIDTH, WINDOW)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             add,
  input  logic [WIDTH-1:0] data,
  output logic [SW-1:0]    nxt_sum,
  output logic [WIDTH-1:0] nxt_min,
  output logic [WIDTH-1:0] nxt_max,
  output logic             last
);
  localparam int CW = $clog2(WINDOW);
  logic [SW-1:0] acc_sum;
  logic [WIDTH-1:0] acc_min, acc_max;
  logic [CW-1:0] cnt;
  assign nxt_sum = acc_sum + SW'(data);
  assign nxt_min = data < acc_min ? data : acc_min;
  assign nxt_max = data > acc_max ? data : acc_max;
  assign last = add && cnt == CW'(WINDOW - 1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_sum <= '0;
      acc_min <= '0;
      acc_max <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc_sum <= '0;
      acc_min <= '1;
      acc_max <= '0;
      cnt <= '0;
    end else if (add) begin
      acc_sum <= nxt_sum;
      acc_min <= nxt_min;
      acc_max <= nxt_max;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/window_stats.sv
// window_stats: collects WINDOW samples, reports sum/min/max over valid/ready, counts drops.
module window_stats import window_stats_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int WINDOW = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [WIDTH-1:0]                    in_data,
  output logic                                busy,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [sum_width(WIDTH, WINDOW)-1:0] res_sum,
  output logic [WIDTH-1:0]                    res_min,
  output logic [WIDTH-1:0]                    res_max,
  output logic [DROP_W-1:0]                   drop_cnt
);
  localparam int SW = sum_width(WIDTH, WINDOW);
  state_t state, state_n;
  logic last;
  logic [SW-1:0] nxt_sum;
  logic [WIDTH-1:0] nxt_min, nxt_max;
  window_stats_accum #(.WIDTH(WIDTH), .WINDOW(WINDOW), .SW(SW)) u_accum (
    .clk(clk),
    .reset_n(reset_n),
    .clr(state == IDLE && start),
    .add(state == ACCUM && in_valid),
    .data(in_data),
    .nxt_sum(nxt_sum),
    .nxt_min(nxt_min),
    .nxt_max(nxt_max),
    .last(last)
  );
  assign busy = state != IDLE;
  assign res_valid = state == REPORT;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (start ? ACCUM : IDLE)
            : state == ACCUM ? (last ? REPORT : ACCUM)
            : (res_ready ? IDLE : REPORT);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      res_sum <= '0;
      res_min <= '0;
      res_max <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == ACCUM && last) begin
        res_sum <= nxt_sum;
        res_min <= nxt_min;
        res_max <= nxt_max;
      end
      if (state == REPORT && in_valid && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule
